// File: rtl/baudot_rx_sequencer.sv
// Baudot line deframer with LTRS/FIGS shift tracking and a symbol FIFO toward the ASCII path.
// Optional macro BAUDOT_UNSHIFT_ON_SPACE_EN: a committed SPACE drops back to LTRS after queueing.
module baudot_rx_sequencer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baudot_in,
  output logic       sym_valid,
  output logic [5:0] sym_data,
  input  logic       sym_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       figs_state
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [4:0] CODE_LTRS  = 5'b11111;
  localparam logic [4:0] CODE_FIGS  = 5'b11011;
  localparam logic [4:0] CODE_NULL  = 5'b00000;
  localparam logic [4:0] CODE_SPACE = 5'b00100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  // state is left as a named signal so checkers can bind to it directly.
  state_t        state, state_nx;
  logic [CW-1:0] clk_cnt, clk_cnt_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [4:0]    code, code_nx;
  logic          commit, stop_bad;

  logic sync1, sync2, sync_d;
  logic fall;

  // Synchronizer flops reset high so a reset release on an idle line is not a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= baudot_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign fall = sync_d && !sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      code    <= '0;
    end else begin
      state   <= state_nx;
      clk_cnt <= clk_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      code    <= code_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clk_cnt_nx = clk_cnt;
    bit_cnt_nx = bit_cnt;
    code_nx    = code;
    commit     = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_nx   = S_START;
          clk_cnt_nx = '0;
          bit_cnt_nx = '0;
        end
      end
      S_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nx = '0;
          state_nx   = sync2 ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_nx = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_nx = '0;
          code_nx    = {sync2, code[4:1]};
          if (bit_cnt == 3'd4) begin
            state_nx = S_STOP;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_nx = clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_nx = '0;
          if (sync2) begin
            commit   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_nx = S_WAIT_HI;
          end
        end else begin
          clk_cnt_nx = clk_cnt + 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (sync2) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign rx_busy = (state != S_IDLE);

  logic is_ltrs, is_figs, is_null, is_space;
  logic push_req;
  logic figs_nx;

  assign is_ltrs  = (code == CODE_LTRS);
  assign is_figs  = (code == CODE_FIGS);
  assign is_null  = (code == CODE_NULL);
  assign is_space = (code == CODE_SPACE);
  assign push_req = commit && !is_ltrs && !is_figs && !is_null;

  always_comb begin
    figs_nx = figs_state;
    if (commit && is_ltrs) figs_nx = 1'b0;
    if (commit && is_figs) figs_nx = 1'b1;
`ifdef BAUDOT_UNSHIFT_ON_SPACE_EN
    if (commit && is_space) figs_nx = 1'b0;
`else
    if (commit && is_space) figs_nx = figs_state;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      figs_state <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      figs_state <= figs_nx;
      frame_err  <= stop_bad;
    end
  end

  // Handshake: a symbol transfers on any clk edge where sym_valid && sym_ready;
  // the head and sym_valid hold until then, and sym_ready without sym_valid does nothing.
  logic [5:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push_ok, ovf_set;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = sym_valid && sym_ready;
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  assign sym_valid = !empty;
  assign sym_data  = empty ? 6'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {figs_state, code};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baudot_rx_sequencer.sv
// Directed bench for baudot_rx_sequencer: serial frame driver, symbol scoreboard, summary report.
module tb_baudot_rx_sequencer;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       baudot_in;
  logic       sym_valid;
  logic [5:0] sym_data;
  logic       sym_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overflow;
  logic       ovf_clr;
  logic       figs_state;

  int n_tests = 0;
  int n_fail  = 0;
  int ferr_cnt = 0;
  logic       model_figs;
  logic [5:0] exp_q[$];
  logic [5:0] got_q[$];

  baudot_rx_sequencer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .baudot_in(baudot_in),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .rx_busy(rx_busy), .frame_err(frame_err), .overflow(overflow),
    .ovf_clr(ovf_clr), .figs_state(figs_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // output monitor
  always @(negedge clk) begin
    if (rst_n && sym_valid && sym_ready) got_q.push_back(sym_data);
    if (rst_n && frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic b);
    baudot_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [4:0] c, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(c[i]);
    drive_bit(stop_bit);
    if (stop_bit) drive_bit(1'b1);
  endtask

  task automatic send_code(input logic [4:0] c);
    if (c == 5'b11111) model_figs = 1'b0;
    else if (c == 5'b11011) model_figs = 1'b1;
    else if (c != 5'b00000) begin
      exp_q.push_back({model_figs, c});
`ifdef BAUDOT_UNSHIFT_ON_SPACE_EN
      if (c == 5'b00100) model_figs = 1'b0;
`endif
    end
    send_frame(c, 1'b1);
  endtask

  // scoreboard
  task automatic check_sb(input string tag);
    logic [5:0] e, g;
    for (int i = 0; i < 2000 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check({tag, "_missing"}, 32'hdead, {26'd0, e});
      end else begin
        g = got_q.pop_front();
        check(tag, {26'd0, g}, {26'd0, e});
      end
    end
    check({tag, "_extra"}, got_q.size(), 0);
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, sym_valid, 1'b0);
    check({tag, "_data"},  sym_data, 6'd0);
    check({tag, "_busy"},  rx_busy, 1'b0);
    check({tag, "_ferr"},  frame_err, 1'b0);
    check({tag, "_ovf"},   overflow, 1'b0);
    check({tag, "_figs"},  figs_state, 1'b0);
  endtask

  initial begin
    logic ok;
    int   f0;
    rst_n = 1'b0; baudot_in = 1'b1; sym_ready = 1'b0; ovf_clr = 1'b0;
    model_figs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 1: plain letter
    sym_ready = 1'b1;
    send_code(5'b00011);
    check_sb("t1_sym");
    check("t1_figs", figs_state, 1'b0);

    // 2: FIGS shift, held head
    sym_ready = 1'b0;
    send_code(5'b11011);
    check("t2_figs", figs_state, 1'b1);
    check("t2_no_figs_sym", sym_valid, 1'b0);
    send_code(5'b00001);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(sym_valid === 1'b1 && sym_data === 6'b100001)) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("t2_hold", ok, 1'b1);
    sym_ready = 1'b1;
    check_sb("t2_sym");
    send_code(5'b11111);
    check("t2_ltrs", figs_state, 1'b0);
    check_sb("t2_after_ltrs");

    // 3: overflow with four-entry FIFO
    sym_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(5'b00011, 1'b1);
    check("t3_ovf_set", overflow, 1'b1);
    check("t3_valid", sym_valid, 1'b1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("t3_ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(6'b000011);
    sym_ready = 1'b1;
    check_sb("t3_drain");
    check("t3_empty", sym_valid, 1'b0);

    // 4: framing error followed by a long break
    f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(i[0]);
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("t4_wait_hi_busy", rx_busy, 1'b1);
    repeat (3) drive_bit(1'b0);
    repeat (3) drive_bit(1'b1);
    check("t4_ferr_pulses", ferr_cnt - f0, 1);
    check("t4_idle", rx_busy, 1'b0);
    check_sb("t4_nothing");

    // 5: short low glitch
    baudot_in = 1'b0;
    repeat (CPB/2 - 1) @(posedge clk);
    #1;
    baudot_in = 1'b1;
    repeat (4 - (CPB/2 - 1)) @(posedge clk);
    #1;
    check("t5_start_seen", rx_busy, 1'b1);
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("t5_back_idle", rx_busy, 1'b0);
    check_sb("t5_nothing");

    // 6: FIGS, SPACE, letter
    send_code(5'b11011);
    send_code(5'b00100);
    send_code(5'b00001);
    check_sb("t6_sym");
    check("t6_figs", figs_state, model_figs);

    // reset in the middle of the data bits
    send_code(5'b11011);
    check("t6_figs_before_rst", figs_state, 1'b1);
    sym_ready = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (CPB/2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_figs = 1'b0;
    #2;
    check_reset_outputs("mid_rst");
    baudot_in = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8 * CPB) @(posedge clk);
    #1;
    check("post_rst_valid", sym_valid, 1'b0);
    check("post_rst_busy", rx_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
